dtmf_bin_decoder: RTL
=====================

Name: dtmf_bin_decoder

Overview:
- Consumes the frequency-bin stream produced by the DTMF FFT stage, i.e. the FFT result bus plus its frame sync.
- Captures the power of the 4 DTMF row bins and 4 column bins, then picks the strongest row and column and reports a key code once per FFT frame.
- Sits directly downstream of the FFT module and feeds the key-reporting logic.

Parameters:
- OWIDTH, 8, width of each real/imag component on i_result.
- LOG2N, 8, log2 of FFT length; N = 2^LOG2N bins per frame.
- ROW_BINS, {8'd30,8'd27,8'd25,8'd22}, packed 4×LOG2N row bin indices, index 0 in LSBs (697/770/852/941 Hz at 8 kHz, N=256).
- COL_BINS, {8'd52,8'd47,8'd43,8'd39}, packed 4×LOG2N column bin indices (1209/1336/1477/1633 Hz).
- THRESH, 16'd64, minimum bin power for a tone to count; width 2*OWIDTH.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_ce  input  1  bin-valid strobe; i_result and i_sync are sampled only when high.
- i_result  input  2*OWIDTH  FFT bin; [2*OWIDTH-1:OWIDTH] = real, [OWIDTH-1:0] = imag, both two's complement.
- i_sync  input  1  high with bin 0 of each frame (qualified by i_ce).
- o_valid  output  1  one-cycle pulse: frame evaluated, o_detect/o_key updated.
- o_detect  output  1  1 = valid key found in last evaluated frame.
- o_key  output  4  {row_idx[1:0], col_idx[1:0]}; held until next o_valid.
- o_overrun  output  1  one-cycle pulse: i_sync arrived while EVAL/REPORT busy; that frame is dropped.

Behaviour:
- Reset (i_reset=0, async): state=IDLE, bin counter=0, all 8 stored powers=0, all outputs 0.
- Power per bin = re*re + im*im, unsigned, computed combinationally from i_result, width 2*OWIDTH+1. It is compared against THRESH zero-extended.
- States: IDLE, COLLECT, EVAL, REPORT.
- IDLE:
  - Bins without sync are ignored.
  - On i_ce & i_sync: clear all stored powers, treat the current sample as bin 0, set the counter to 1, go to COLLECT.
- COLLECT, on each i_ce:
  - If the counter matches ROW_BINS[k], store power in row_pwr[k]. Same rule for COL_BINS[k] into col_pwr[k]. Bin 0 is also checked in IDLE.
  - Increment the counter.
  - When the sample with index N-1 is consumed, go to EVAL.
  - i_sync with i_ce in COLLECT restarts the frame: clear powers, that sample becomes bin 0, counter=1.
  - No i_ce: hold.
- EVAL:
  - Exactly 4 cycles, independent of i_ce.
  - Scan index s=0..3 over row and column in parallel, tracking max value, max index and a tie flag.
  - A value strictly greater than the current max replaces it and clears tie. Equal to the current max sets tie.
  - Initial max = 0, tie = 0.
  - Then go to REPORT.
- REPORT:
  - One cycle. o_valid=1.
  - o_detect=1 iff row max >= THRESH, col max >= THRESH, and neither tie flag is set.
  - o_key = {row_idx, col_idx} if detect, else o_key = 4'h0.
  - Return to IDLE.
- Overrun: i_ce & i_sync during EVAL or REPORT pulses o_overrun for 1 cycle. The block does not start a frame; it resynchronises on the next sync seen in IDLE.
- Latency: o_valid is asserted 5 clocks after the clock edge that consumes bin N-1.
- Counter wraps at N. Bins with index >= N/2 are counted but never match (parameters < N/2).

Optional Feature:
- Macro DTMF_DEBOUNCE_EN.
- With it defined:
  - A register holds the previous frame's {detect, key}.
  - o_detect=1 only if the current frame detects and its key equals the previous frame's detected key. A first or changed key reports o_detect=0 with o_key=0.
  - The history register is cleared by reset and by a non-detect frame.
- Without it: raw per-frame decision as above.

Test Plan:
- Tone pair: frame with bin 22 = (40,0) and bin 39 = (0,-40), all others 0 → o_valid 5 clocks after bin 255, o_detect=1, o_key=4'h0. With DEBOUNCE_EN, the same result needs 2 frames; the first reports o_detect=0.
- Row 3 / col 2: bins 30 = (20,20) and 47 = (30,0), plus noise (2,2) on all other bins → o_detect=1, o_key=4'hE.
- Below threshold: bins 22 and 39 = (7,0) (power 49 < 64) → o_valid=1, o_detect=0, o_key=0.
- Tie: bins 25 and 27 both (40,0), bin 43 = (40,0) → o_detect=0.
- Restart and overrun:
  - i_sync reasserted at bin 100 → the frame is re-based and o_valid comes 256 bins later.
  - i_sync during EVAL → o_overrun pulse, no o_valid for that frame.
- Async reset asserted mid-COLLECT with i_clk stopped → outputs 0 immediately. After release, bins without sync produce no o_valid.

Source files
------------

// File: rtl/dtmf_bin_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dtmf_bin_decoder_if
//  Purpose  : Bus between the DTMF FFT stage and the DTMF bin decoder.
//             Carries the FFT bin stream (strobe, bin value, frame sync)
//             and the per-frame key report returned by the decoder.
//  Signals  : i_ce      bin-valid strobe
//             i_result  {real, imag}, each OWIDTH bits, two's complement
//             i_sync    marks bin 0 of a frame (qualified by i_ce)
//             o_valid   one-cycle pulse, frame evaluated
//             o_detect  a valid key was found in the last evaluated frame
//             o_key     {row_idx, col_idx}
//             o_overrun one-cycle pulse, sync dropped while busy
//  Modports : master = FFT side, slave = decoder side
//  Revision : 1.0  initial release
// ============================================================================
interface dtmf_bin_decoder_if #(
    parameter int OWIDTH = 8
);
    logic                  i_ce;
    logic [2*OWIDTH-1:0]   i_result;
    logic                  i_sync;
    logic                  o_valid;
    logic                  o_detect;
    logic [3:0]            o_key;
    logic                  o_overrun;

    modport master (
        output i_ce, i_result, i_sync,
        input  o_valid, o_detect, o_key, o_overrun
    );

    modport slave (
        input  i_ce, i_result, i_sync,
        output o_valid, o_detect, o_key, o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/dtmf_bin_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dtmf_bin_decoder
//  Purpose  : Captures the power of the four DTMF row bins and four column
//             bins from an FFT bin stream, picks the strongest row and column
//             once per frame and reports a key code.
//  Ports    : i_clk    system clock, rising edge
//             i_reset  asynchronous active-low reset
//             bus      dtmf_bin_decoder_if.slave (bin stream in, report out)
//  Options  : DTMF_DEBOUNCE_EN - when defined, a key is only reported as
//             detected when the previous frame detected the same key.
//  Revision : 1.0  initial release
// ============================================================================
module dtmf_bin_decoder #(
    parameter int                  OWIDTH   = 8,
    parameter int                  LOG2N    = 8,
    parameter logic [4*LOG2N-1:0]  ROW_BINS = {8'd30, 8'd27, 8'd25, 8'd22},
    parameter logic [4*LOG2N-1:0]  COL_BINS = {8'd52, 8'd47, 8'd43, 8'd39},
    parameter logic [2*OWIDTH-1:0] THRESH   = 16'd64
) (
    input  wire logic         i_clk,
    input  wire logic         i_reset,
    dtmf_bin_decoder_if.slave bus
);
    localparam int PW = 2*OWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_EVAL    = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [LOG2N-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]     row_pwr_q [4];
    logic [PW-1:0]     row_pwr_d [4];
    logic [PW-1:0]     col_pwr_q [4];
    logic [PW-1:0]     col_pwr_d [4];
    logic [1:0]        scan_q, scan_d;
    logic [PW-1:0]     row_max_q, row_max_d, col_max_q, col_max_d;
    logic [1:0]        row_idx_q, row_idx_d, col_idx_q, col_idx_d;
    logic              row_tie_q, row_tie_d, col_tie_q, col_tie_d;
    logic              valid_q, valid_d, overrun_q, overrun_d;
    logic              detect_q, detect_d;
    logic [3:0]        key_q, key_d;
`ifdef DTMF_DEBOUNCE_EN
    logic              hist_det_q, hist_det_d;
    logic [3:0]        hist_key_q, hist_key_d;
`endif

    // Bin power: squares of sign-extended components are non-negative and
    // fit in 2*OWIDTH bits; the sum needs one more bit.
    logic signed [2*OWIDTH-1:0] w_re, w_im, w_re_sq, w_im_sq;
    logic [PW-1:0]              w_pwr;
    logic                       w_start;
    logic                       w_raw_det;
    logic [3:0]                 w_raw_key;

    assign w_re      = {{OWIDTH{bus.i_result[2*OWIDTH-1]}}, bus.i_result[2*OWIDTH-1:OWIDTH]};
    assign w_im      = {{OWIDTH{bus.i_result[OWIDTH-1]}}, bus.i_result[OWIDTH-1:0]};
    assign w_re_sq   = w_re * w_re;
    assign w_im_sq   = w_im * w_im;
    assign w_pwr     = {1'b0, w_re_sq} + {1'b0, w_im_sq};
    assign w_start   = bus.i_ce && bus.i_sync;
    assign w_raw_det = (row_max_q >= {1'b0, THRESH}) && (col_max_q >= {1'b0, THRESH})
                       && !row_tie_q && !col_tie_q;
    assign w_raw_key = {row_idx_q, col_idx_q};

    always_comb begin
        logic             capture;
        logic [LOG2N-1:0] bin;
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_pwr_d = row_pwr_q;
        col_pwr_d = col_pwr_q;
        scan_d    = scan_q;
        row_max_d = row_max_q;
        row_idx_d = row_idx_q;
        row_tie_d = row_tie_q;
        col_max_d = col_max_q;
        col_idx_d = col_idx_q;
        col_tie_d = col_tie_q;
        valid_d   = 1'b0;
        overrun_d = 1'b0;
        detect_d  = detect_q;
        key_d     = key_q;
`ifdef DTMF_DEBOUNCE_EN
        hist_det_d = hist_det_q;
        hist_key_d = hist_key_q;
`endif
        capture   = 1'b0;
        bin       = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (w_start) begin
                    for (int k = 0; k < 4; k++) begin
                        row_pwr_d[k] = '0;
                        col_pwr_d[k] = '0;
                    end
                    capture = 1'b1;
                    bin     = '0;
                    cnt_d   = LOG2N'(1);
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (bus.i_ce) begin
                    capture = 1'b1;
                    if (bus.i_sync) begin
                        // Resync: this sample re-bases the frame as bin 0
                        for (int k = 0; k < 4; k++) begin
                            row_pwr_d[k] = '0;
                            col_pwr_d[k] = '0;
                        end
                        bin   = '0;
                        cnt_d = LOG2N'(1);
                    end else begin
                        cnt_d = cnt_q + LOG2N'(1);
                        if (cnt_q == '1) begin
                            state_d   = S_EVAL;
                            scan_d    = 2'd0;
                            row_max_d = '0;
                            row_idx_d = 2'd0;
                            row_tie_d = 1'b0;
                            col_max_d = '0;
                            col_idx_d = 2'd0;
                            col_tie_d = 1'b0;
                        end
                    end
                end
            end
            S_EVAL: begin
                // One row and one column candidate per cycle; an equal value
                // marks the maximum as ambiguous until a larger one appears.
                if (row_pwr_q[scan_q] > row_max_q) begin
                    row_max_d = row_pwr_q[scan_q];
                    row_idx_d = scan_q;
                    row_tie_d = 1'b0;
                end else if (row_pwr_q[scan_q] == row_max_q) begin
                    row_tie_d = 1'b1;
                end
                if (col_pwr_q[scan_q] > col_max_q) begin
                    col_max_d = col_pwr_q[scan_q];
                    col_idx_d = scan_q;
                    col_tie_d = 1'b0;
                end else if (col_pwr_q[scan_q] == col_max_q) begin
                    col_tie_d = 1'b1;
                end
                scan_d = scan_q + 2'd1;
                if (scan_q == 2'd3) begin
                    state_d = S_REPORT;
                end
                overrun_d = w_start;
            end
            S_REPORT: begin
                valid_d   = 1'b1;
                overrun_d = w_start;
                state_d   = S_IDLE;
`ifdef DTMF_DEBOUNCE_EN
                if (w_raw_det) begin
                    hist_det_d = 1'b1;
                    hist_key_d = w_raw_key;
                    if (hist_det_q && (hist_key_q == w_raw_key)) begin
                        detect_d = 1'b1;
                        key_d    = w_raw_key;
                    end else begin
                        detect_d = 1'b0;
                        key_d    = 4'h0;
                    end
                end else begin
                    hist_det_d = 1'b0;
                    hist_key_d = 4'h0;
                    detect_d   = 1'b0;
                    key_d      = 4'h0;
                end
`else
                detect_d = w_raw_det;
                key_d    = w_raw_det ? w_raw_key : 4'h0;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Bin capture runs after any clear so bin 0 can land in a cleared slot
        if (capture) begin
            for (int k = 0; k < 4; k++) begin
                if (bin == ROW_BINS[k*LOG2N +: LOG2N]) row_pwr_d[k] = w_pwr;
                if (bin == COL_BINS[k*LOG2N +: LOG2N]) col_pwr_d[k] = w_pwr;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            for (int k = 0; k < 4; k++) begin
                row_pwr_q[k] <= '0;
                col_pwr_q[k] <= '0;
            end
            scan_q    <= 2'd0;
            row_max_q <= '0;
            row_idx_q <= 2'd0;
            row_tie_q <= 1'b0;
            col_max_q <= '0;
            col_idx_q <= 2'd0;
            col_tie_q <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            detect_q  <= 1'b0;
            key_q     <= 4'h0;
`ifdef DTMF_DEBOUNCE_EN
            hist_det_q <= 1'b0;
            hist_key_q <= 4'h0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_pwr_q <= row_pwr_d;
            col_pwr_q <= col_pwr_d;
            scan_q    <= scan_d;
            row_max_q <= row_max_d;
            row_idx_q <= row_idx_d;
            row_tie_q <= row_tie_d;
            col_max_q <= col_max_d;
            col_idx_q <= col_idx_d;
            col_tie_q <= col_tie_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            detect_q  <= detect_d;
            key_q     <= key_d;
`ifdef DTMF_DEBOUNCE_EN
            hist_det_q <= hist_det_d;
            hist_key_q <= hist_key_d;
`endif
        end
    end

    assign bus.o_valid   = valid_q;
    assign bus.o_detect  = detect_q;
    assign bus.o_key     = key_q;
    assign bus.o_overrun = overrun_q;

endmodule
`default_nettype wire
